rv64g_instr_window_launcher: RTL

// - Out-of-order-capable issue window between decoder and execution units; successor of the fixed

---
 rtl/rv64g_instr_window_launcher.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rv64g_instr_window_launcher.sv
// rv64g_instr_window_launcher
//   Issue window between the decoder and the execution units. It holds up to
//   DEPTH decoded instructions in age order, with slot 0 the oldest. Each cycle
//   it offers the oldest entry whose registers are neither locked by in-flight
//   work nor shared with any older buffered entry. A younger independent
//   instruction can therefore overtake a stalled older one, while RAW, WAR and
//   WAW ordering between buffered entries is preserved.
//
//   Optional feature: define RV64G_LAUNCHER_PERF_EN to add stall_cnt_o.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   clear_i               synchronous flush of every buffered entry
//   instr_in_*_i/_o       push side: payload, register mask, valid/ready
//   locks_i               registers currently held by in-flight instructions
//   instr_out_*_o/_i      launch side: payload, register mask, valid/ready
//   stall_cnt_o           (macro only) cycles with work buffered but no launch
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// instr_in_ready_o depends on registered state and clear_i only. The launch
// valid is combinational from the slots and locks_i, so it may drop or move to
// another slot when locks_i changes before it is accepted.

package rv64g_pkg;
  localparam int NUM_REGS        = 64;  // 32 integer + 32 floating point
  localparam int NUM_OUTSTANDING = 4;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decoded_instr_t;
endpackage

module rv64g_instr_window_launcher #(
  parameter int DW    = $bits(rv64g_pkg::decoded_instr_t),
  parameter int NR    = rv64g_pkg::NUM_REGS,
  parameter int DEPTH = rv64g_pkg::NUM_OUTSTANDING
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [DW-1:0] instr_in_i,
  input  logic [NR-1:0] instr_in_regs_i,
  input  logic          instr_in_valid_i,
  output logic          instr_in_ready_o,
  input  logic [NR-1:0] locks_i,
  output logic [DW-1:0] instr_out_o,
  output logic [NR-1:0] instr_out_regs_o,
  output logic          instr_out_valid_o,
  input  logic          instr_out_ready_i
`ifdef RV64G_LAUNCHER_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [NR-1:0]    regs_q [DEPTH];
  logic [NR-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DEPTH-1:0] elig;
  logic [NR-1:0]    older_regs;
  logic             any_elig;
  logic [IW-1:0]    sel_idx;
  logic [CW-1:0]    wr_idx;
  logic             launch_fire;
  logic             push_fire;

  // Selection: walk from oldest to youngest, accumulating the registers used
  // by every valid older slot. The first slot clear of both locks and older
  // usage wins.
  always_comb begin
    older_regs = '0;
    any_elig   = 1'b0;
    sel_idx    = '0;
    elig       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = vld_q[i] && ((regs_q[i] & locks_i) == '0)
                         && ((regs_q[i] & older_regs) == '0);
      if (vld_q[i]) older_regs = older_regs | regs_q[i];
      if (elig[i] && !any_elig) begin
        any_elig = 1'b1;
        sel_idx  = IW'(i);
      end
    end
  end

  // With nothing eligible sel_idx stays 0, so the outputs show slot 0.
  assign instr_out_o       = data_q[sel_idx];
  assign instr_out_regs_o  = regs_q[sel_idx];
  assign instr_out_valid_o = any_elig && !clear_i;
  assign instr_in_ready_o  = (cnt_q < FULL) && !clear_i;

  assign launch_fire = instr_out_valid_o && instr_out_ready_i;
  assign push_fire   = instr_in_valid_i && instr_in_ready_o;

  // Next state: close the gap left by the launched slot, then append the new
  // entry at the tail of the compacted window.
  always_comb begin
    data_d = data_q;
    regs_d = regs_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    wr_idx = launch_fire ? (cnt_q - CW'(1)) : cnt_q;
    if (clear_i) begin
      vld_d = '0;
      cnt_d = '0;
    end else begin
      if (launch_fire) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (IW'(i) >= sel_idx) begin
            data_d[i] = data_q[i+1];
            regs_d[i] = regs_q[i+1];
            vld_d[i]  = vld_q[i+1];
          end
        end
        vld_d[DEPTH-1] = 1'b0;
      end
      if (push_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) begin
            data_d[i] = instr_in_i;
            regs_d[i] = instr_in_regs_i;
            vld_d[i]  = 1'b1;
          end
        end
      end
      cnt_d = cnt_q + CW'(push_fire) - CW'(launch_fire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage carries no reset; vld_q alone qualifies it.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    regs_q <= regs_d;
  end

`ifdef RV64G_LAUNCHER_PERF_EN
  logic [31:0] stall_q;

  // A flush cycle is not a stall, so clear_i holds the count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((cnt_q != '0) && !launch_fire && !clear_i) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
